// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types for the sprite line engine.
//   coord_t  - 10-bit screen coordinate
//   state_t  - line-preparation FSM states
//   LINE_AW  - line-buffer address width (coordinates are 10 bits, so a
//              line never exceeds 1024 entries)
package sprite_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CHECK,
    FETCH,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned LINE_AW      = $clog2(DEF_SCREEN_W);

endpackage

// File: rtl/sprite_line_engine_line_buffer.sv
// line_buffer: ping-pong scanline storage, two SCREEN_W x PIX_W simple
// dual-port RAMs.
//   clk     - system clock
//   wr_sel  - selects the RAM being written; the other one is read
//   wr_en   - write strobe
//   wr_addr - write entry
//   wr_data - palette index to store
//   rd_addr - display X
//   rd_data - registered read data (1-cycle latency)
module line_buffer
  import sprite_pkg::*;
#(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned PIX_W    = 4
) (
  input  logic               clk,
  input  logic               wr_sel,
  input  logic               wr_en,
  input  logic [LINE_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic [LINE_AW-1:0] rd_addr,
  output logic [PIX_W-1:0]   rd_data
);

  logic [PIX_W-1:0] buf0 [SCREEN_W];
  logic [PIX_W-1:0] buf1 [SCREEN_W];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < SCREEN_W)) begin
      if (wr_sel) buf1[wr_addr] <= wr_data;
      else        buf0[wr_addr] <= wr_data;
    end
    if (32'(rd_addr) < SCREEN_W)
      rd_data <= wr_sel ? buf0[rd_addr] : buf1[rd_addr];
  end

endmodule

// File: rtl/sprite_line_engine.sv
// sprite_line_engine: multi-sprite scanline renderer.
// During line N, every sprite row intersecting line N+1 is fetched from the
// spritesheet RAM into the write half of a ping-pong line buffer; the other
// half is read out per DrawX as a palette index plus opaque flag.
//
// Ports:
//   Clk, Reset_n            - 50 MHz clock, async active-low reset
//   line_start, next_line   - hblank pulse and Y of the line to prepare
//   spr_x/spr_y/spr_id      - packed per-slot position and frame ID
//   spr_en, spr_flip        - per-slot enable and horizontal mirror
//   mem_addr/mem_rd/mem_data- spritesheet read port (data 1 cycle after rd)
//   DrawX                   - current display X
//   pix_index, pix_opaque   - palette index for DrawX, 1-cycle latency
//   busy                    - preparation in progress
//   overrun                 - sticky: line_start arrived while busy
//
// Build option: define SPRITE_HFLIP_EN to honour spr_flip; otherwise the
// port is present but ignored.
module sprite_line_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned SPRITE_W    = 16,
  parameter int unsigned SPRITE_H    = 16,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned PIX_W       = 4,
  parameter int unsigned SHEET_AW    = 14,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned TRANSP_IDX  = 0
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        line_start,
  input  logic [9:0]                  next_line,
  input  logic [10*NUM_SPRITES-1:0]   spr_x,
  input  logic [10*NUM_SPRITES-1:0]   spr_y,
  input  logic [ID_W*NUM_SPRITES-1:0] spr_id,
  input  logic [NUM_SPRITES-1:0]      spr_en,
  input  logic [NUM_SPRITES-1:0]      spr_flip,
  output logic [SHEET_AW-1:0]         mem_addr,
  output logic                        mem_rd,
  input  logic [PIX_W-1:0]            mem_data,
  input  logic [9:0]                  DrawX,
  output logic [PIX_W-1:0]            pix_index,
  output logic                        pix_opaque,
  output logic                        busy,
  output logic                        overrun
);

  localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned KW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [PIX_W-1:0] TRANSP = PIX_W'(TRANSP_IDX);

  state_t state, state_n;

  // line snapshot taken at line_start
  coord_t                  ty_q;
  coord_t                  sx_q  [NUM_SPRITES];
  coord_t                  sy_q  [NUM_SPRITES];
  logic [ID_W-1:0]         sid_q [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  sen_q;

  logic [KW-1:0]      k_q;
  logic [CW-1:0]      col_q;
  logic [LINE_AW-1:0] clr_q;
  logic               wr_sel_q;
  logic               valid_line_q;
  logic               prep_done_q;
  logic               overrun_q;
  logic               show_q;

  // read issued last cycle; its datum is on mem_data now
  logic               wb_valid_q;
  logic [10:0]        wb_x_q;

  logic               lb_we;
  logic [LINE_AW-1:0] lb_waddr;
  logic [PIX_W-1:0]   lb_wdata;
  logic [PIX_W-1:0]   lb_rdata;

  coord_t        row;
  logic          hit;
  logic [CW-1:0] c;

  // 10-bit wrap makes sprites straddling Y=1023/0 hit correctly
  assign row = ty_q - sy_q[k_q];
  assign hit = sen_q[k_q] && (row < coord_t'(SPRITE_H));

`ifdef SPRITE_HFLIP_EN
  logic [NUM_SPRITES-1:0] sflip_q;
  assign c = sflip_q[k_q] ? (CW'(SPRITE_W - 1) - col_q) : col_q;
`else
  logic unused_flip;
  assign unused_flip = ^spr_flip;
  assign c = col_q;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    busy     = 1'b1;
    mem_rd   = 1'b0;
    mem_addr = '0;
    lb_we    = 1'b0;
    lb_waddr = '0;
    lb_wdata = TRANSP;
    unique case (state)
      IDLE:  busy = 1'b0;
      CLEAR: begin
        lb_we    = 1'b1;
        lb_waddr = clr_q;
        if (clr_q == LINE_AW'(SCREEN_W - 1)) state_n = CHECK;
      end
      CHECK: state_n = hit ? FETCH : NEXT;
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = SHEET_AW'(32'(sid_q[k_q]) * (SPRITE_W * SPRITE_H)
                             + 32'(row) * SPRITE_W + 32'(c));
        if (col_q == CW'(SPRITE_W - 1)) state_n = DRAIN;
      end
      DRAIN: state_n = NEXT;
      NEXT:  state_n = (k_q == '0) ? DONE : CHECK;
      DONE: begin
        busy    = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // write-back never overlaps CLEAR: the pipeline is flushed on line_start
    if (wb_valid_q && (mem_data != TRANSP) && (wb_x_q < 11'(SCREEN_W))) begin
      lb_we    = 1'b1;
      lb_waddr = wb_x_q[LINE_AW-1:0];
      lb_wdata = mem_data;
    end
    if (line_start) state_n = CLEAR;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ty_q         <= '0;
      sen_q        <= '0;
      k_q          <= '0;
      col_q        <= '0;
      clr_q        <= '0;
      wr_sel_q     <= 1'b0;
      valid_line_q <= 1'b0;
      prep_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      show_q       <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_x_q       <= '0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        sx_q[i]  <= '0;
        sy_q[i]  <= '0;
        sid_q[i] <= '0;
      end
`ifdef SPRITE_HFLIP_EN
      sflip_q <= '0;
`endif
    end else begin
      if (line_start) begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          sx_q[i]  <= spr_x[i*10 +: 10];
          sy_q[i]  <= spr_y[i*10 +: 10];
          sid_q[i] <= spr_id[i*ID_W +: ID_W];
        end
`ifdef SPRITE_HFLIP_EN
        sflip_q <= spr_flip;
`endif
        sen_q        <= spr_en;
        ty_q         <= next_line;
        wr_sel_q     <= ~wr_sel_q;
        // a line arriving in DONE itself still counts as completed
        valid_line_q <= prep_done_q || (state == DONE);
        prep_done_q  <= 1'b0;
        clr_q        <= '0;
        overrun_q    <= overrun_q | busy;
        wb_valid_q   <= 1'b0;
      end else begin
        wb_valid_q <= (state == FETCH);
        wb_x_q     <= {1'b0, sx_q[k_q]} + 11'(col_q);
        unique case (state)
          CLEAR: begin
            clr_q <= clr_q + 1'b1;
            k_q   <= KW'(NUM_SPRITES - 1);
          end
          CHECK:   col_q <= '0;
          FETCH:   col_q <= col_q + 1'b1;
          NEXT:    if (k_q != '0) k_q <= k_q - 1'b1;
          DONE:    prep_done_q <= 1'b1;
          default: ;
        endcase
      end
      show_q <= valid_line_q && (DrawX < coord_t'(SCREEN_W));
    end
  end

  line_buffer #(
    .SCREEN_W (SCREEN_W),
    .PIX_W    (PIX_W)
  ) u_line_buffer (
    .clk     (Clk),
    .wr_sel  (wr_sel_q),
    .wr_en   (lb_we),
    .wr_addr (lb_waddr),
    .wr_data (lb_wdata),
    .rd_addr (DrawX[LINE_AW-1:0]),
    .rd_data (lb_rdata)
  );

  assign overrun    = overrun_q;
  assign pix_index  = show_q ? lb_rdata : TRANSP;
  assign pix_opaque = show_q && (lb_rdata != TRANSP);

endmodule

// File: tb/tb_sprite_line_engine.sv
`timescale 1ns/1ps
module tb_sprite_line_engine;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        line_start;
  logic [9:0]  next_line;
  logic [39:0] spr_x, spr_y;
  logic [15:0] spr_id;
  logic [3:0]  spr_en, spr_flip;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [3:0]  mem_data;
  logic [9:0]  DrawX;
  logic [3:0]  pix_index;
  logic        pix_opaque, busy, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int    idx;
    int    op;
    string name;
  } pexp_t;

  pexp_t pq[$];
  int    aq[$];
  logic  req = 1'b0, req_d = 1'b0;
  logic  aq_en = 1'b0;

  sprite_line_engine #(
    .NUM_SPRITES (4),
    .SPRITE_W    (16),
    .SPRITE_H    (16),
    .ID_W        (4),
    .PIX_W       (4),
    .SHEET_AW    (14),
    .SCREEN_W    (640),
    .TRANSP_IDX  (0)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .line_start (line_start),
    .next_line  (next_line),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_id     (spr_id),
    .spr_en     (spr_en),
    .spr_flip   (spr_flip),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .DrawX      (DrawX),
    .pix_index  (pix_index),
    .pix_opaque (pix_opaque),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #10 Clk = ~Clk;

  // Spritesheet: (addr%15)+1, except frame 5 has transparent even columns.
  function automatic int sheet_val(input int a);
    if (a >= 1280 && a < 1536 && (a % 2) == 0) return 0;
    return (a % 15) + 1;
  endfunction

  always @(posedge Clk) mem_data <= 4'(sheet_val(int'(mem_addr)));
  always @(posedge Clk) req_d <= req;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // pixel monitor: output for a probed DrawX appears one clock later
  always @(negedge Clk) begin
    if (req_d) begin
      if (pq.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        pexp_t e;
        e = pq.pop_front();
        chk({e.name, "_idx"}, int'(pix_index), e.idx);
        chk({e.name, "_op"}, int'(pix_opaque), e.op);
      end
    end
  end

  // read-address monitor
  always @(negedge Clk) begin
    if (aq_en && mem_rd) begin
      if (aq.size() == 0) chk("addr_unexpected", int'(mem_addr), -1);
      else                chk("flip_addr", int'(mem_addr), aq.pop_front());
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic probe(input int x, input int idx, input int op, input string nm);
    DrawX = 10'(x);
    pq.push_back('{idx, op, nm});
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic start_line(input int ny);
    next_line  = 10'(ny);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic set_slot(input int k, input int x, input int y, input int id,
                          input logic en, input logic fl);
    spr_x[k*10 +: 10] = 10'(x);
    spr_y[k*10 +: 10] = 10'(y);
    spr_id[k*4 +: 4]  = 4'(id);
    spr_en[k]         = en;
    spr_flip[k]       = fl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e, n;
    Reset_n = 1'b0; line_start = 1'b0; next_line = '0; DrawX = '0;
    spr_x = '0; spr_y = '0; spr_id = '0; spr_en = '0; spr_flip = '0;
    #3;
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_opaque", int'(pix_opaque), 0);
    chk("rst_index", int'(pix_index), 0);
    repeat (2) tick();
    Reset_n = 1'b1;
    tick();

    // reset asserted in the middle of FETCH
    set_slot(0, 100, 50, 2, 1'b1, 1'b0);
    start_line(53);
    n = 0;
    while (!mem_rd && n < 2000) begin tick(); n++; end
    chk("fetch_reached", int'(mem_rd), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_mem_rd", int'(mem_rd), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overrun", int'(overrun), 0);
    tick();
    Reset_n = 1'b1;
    tick();

    // single sprite: first prepared line is not yet displayable
    start_line(53);
    probe(100, 0, 0, "pre_valid");
    wait_idle("t1_prep");
    start_line(53);
    for (int x = 99; x <= 116; x++) begin
      if (x >= 100 && x <= 115)
        probe(x, ((2*256 + 3*16 + (x-100)) % 15) + 1, 1, $sformatf("t1_x%0d", x));
      else
        probe(x, 0, 0, $sformatf("t1_x%0d", x));
    end
    wait_idle("t1_show");

    // priority: slot 0 (frame 5, holes) over slot 1 (frame 3)
    set_slot(0, 200, 10, 5, 1'b1, 1'b0);
    set_slot(1, 200, 10, 3, 1'b1, 1'b0);
    start_line(10);
    wait_idle("t2_prep");
    start_line(10);
    for (int c = 0; c < 16; c++) begin
      d0 = sheet_val(1280 + c);
      e  = (d0 != 0) ? d0 : sheet_val(768 + c);
      probe(200 + c, e, 1, $sformatf("t2_c%0d", c));
    end
    wait_idle("t2_show");

    // right-edge clip and Y wrap: row (2-1020) mod 1024 = 6
    set_slot(0, 630, 1020, 1, 1'b1, 1'b0);
    set_slot(1, 0, 0, 0, 1'b0, 1'b0);
    start_line(2);
    wait_idle("t3_prep");
    start_line(2);
    for (int x = 0; x < 6; x++) probe(x, 0, 0, $sformatf("t3_nowrap%0d", x));
    for (int c = 0; c < 10; c++)
      probe(630 + c, ((256 + 6*16 + c) % 15) + 1, 1, $sformatf("t3_x%0d", 630 + c));
    probe(640, 0, 0, "t3_offscreen");
    wait_idle("t3_show");

    // overrun: second line_start 500 cycles into a preparation
    start_line(2);
    repeat (499) tick();
    chk("t4_busy_before", int'(busy), 1);
    start_line(2);
    chk("t4_overrun", int'(overrun), 1);
    probe(630, 0, 0, "t4_aborted");
    wait_idle("t4_prep");
    start_line(2);
    probe(630, ((256 + 96) % 15) + 1, 1, "t4_recovered");
    chk("t4_sticky", int'(overrun), 1);
    wait_idle("t4_show");

    // horizontal flip: column order of reads
    set_slot(0, 100, 50, 2, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
`ifdef SPRITE_HFLIP_EN
      aq.push_back(560 + 15 - i);
`else
      aq.push_back(560 + i);
`endif
    end
    aq_en = 1'b1;
    start_line(53);
    wait_idle("t5_prep");
    aq_en = 1'b0;
    chk("t5_addr_left", aq.size(), 0);
    start_line(53);
`ifdef SPRITE_HFLIP_EN
    probe(100, sheet_val(575), 1, "t5_x100");
    probe(115, sheet_val(560), 1, "t5_x115");
`else
    probe(100, sheet_val(560), 1, "t5_x100");
    probe(115, sheet_val(575), 1, "t5_x115");
`endif
    wait_idle("t5_show");

    repeat (3) tick();
    chk("pq_drained", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
